nor_settle_ctrl: RTL and testbench

// - Sequences the clocked NOR-gate netlist: holds gate reset at start-up, applies each logical phase, runs evaluation until quiet.
// - Sits between the simulated timing-pulse source and the gate network; one instance per independently clocked netlist.
// - Detects non-settling (oscillating) logic and halts with a sticky fault.

---
 rtl/nor_settle_ctrl.sv | 126 ++++++++++++
 tb/tb_nor_settle_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_settle_ctrl.sv
// Phase sequencer for a clocked NOR-gate netlist: gate reset, phase apply, settle detect, oscillation fault.
// Optional statistics outputs (max_settle, phase_cnt) are built when NOR_SETTLE_STATS_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_NRST   | gate reset held low for RST_CYCLES after rst_n releases
// S_IDLE   | netlist quiet, waiting for tick_req
// S_APPLY  | one cycle: new phase inputs strobed into the netlist
// S_SETTLE | evaluation running, watching for QUIET_CYCLES quiet cycles
// S_FAULT  | netlist never settled within MAX_CYCLES; held until rst_n
module nor_settle_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int QUIET_CYCLES = 3,
  parameter int MAX_CYCLES   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_req,
  input  logic       net_changed,
  output logic       net_rst_n,
  output logic       eval_en,
  output logic       phase_strobe,
  output logic       busy,
  output logic       settled,
  output logic [7:0] settle_cnt,
  output logic       fault
`ifdef NOR_SETTLE_STATS_EN
  ,
  output logic [7:0]  max_settle,
  output logic [15:0] phase_cnt
`endif
);

  localparam logic [2:0] S_NRST   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [3:0] QUIET_HIT = 4'(QUIET_CYCLES);
  localparam logic [7:0] MAX_HIT   = 8'(MAX_CYCLES);

  logic [2:0] state;
  logic [7:0] rst_cnt;
  logic [7:0] eval_cnt;
  logic [3:0] quiet_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_NRST;
      rst_cnt      <= 8'd0;
      eval_cnt     <= 8'd0;
      quiet_cnt    <= 4'd0;
      net_rst_n    <= 1'b0;
      eval_en      <= 1'b0;
      phase_strobe <= 1'b0;
      busy         <= 1'b0;
      settled      <= 1'b0;
      settle_cnt   <= 8'd0;
      fault        <= 1'b0;
`ifdef NOR_SETTLE_STATS_EN
      max_settle   <= 8'd0;
      phase_cnt    <= 16'd0;
`endif
    end else begin
      phase_strobe <= 1'b0;
      settled      <= 1'b0;
      case (state)
        S_NRST: begin
          if (rst_cnt == RST_LAST) begin
            state     <= S_IDLE;
            net_rst_n <= 1'b1;
            rst_cnt   <= 8'd0;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        S_IDLE: begin
          if (tick_req) begin
            state        <= S_APPLY;
            phase_strobe <= 1'b1;
            busy         <= 1'b1;
            eval_cnt     <= 8'd0;
            quiet_cnt    <= 4'd0;
          end
        end
        S_APPLY: begin
          state     <= S_SETTLE;
          eval_en   <= 1'b1;
          eval_cnt  <= 8'd0;
          quiet_cnt <= 4'd0;
        end
        S_SETTLE: begin
          // settle is checked first so a quiet window ending exactly at the limit still counts
          if (quiet_cnt == QUIET_HIT) begin
            state      <= S_IDLE;
            settled    <= 1'b1;
            settle_cnt <= eval_cnt;
            busy       <= 1'b0;
            eval_en    <= 1'b0;
`ifdef NOR_SETTLE_STATS_EN
            if (eval_cnt > max_settle) max_settle <= eval_cnt;
            phase_cnt <= phase_cnt + 16'd1;
`endif
          end else if (eval_cnt == MAX_HIT) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            settle_cnt <= MAX_HIT;
            busy       <= 1'b0;
            eval_en    <= 1'b0;
          end else begin
            if (eval_cnt != 8'hFF) eval_cnt <= eval_cnt + 8'd1;
            quiet_cnt <= net_changed ? 4'd0 : quiet_cnt + 4'd1;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: begin
          state     <= S_NRST;
          net_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_settle_ctrl.sv
// Self-checking bench for nor_settle_ctrl: vector table, hand corner sequences, random phases vs. a sequence model.
module tb_nor_settle_ctrl;

  localparam int RSTC  = 4;
  localparam int QUIET = 3;
  localparam int MAX   = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_req = 1'b0;
  logic       net_changed = 1'b0;
  logic       net_rst_n, eval_en, phase_strobe, busy, settled, fault;
  logic [7:0] settle_cnt;
`ifdef NOR_SETTLE_STATS_EN
  logic [7:0]  max_settle;
  logic [15:0] phase_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_max = 0;
  int exp_phases = 0;

  nor_settle_ctrl #(.RST_CYCLES(RSTC), .QUIET_CYCLES(QUIET), .MAX_CYCLES(MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_req     (tick_req),
    .net_changed  (net_changed),
    .net_rst_n    (net_rst_n),
    .eval_en      (eval_en),
    .phase_strobe (phase_strobe),
    .busy         (busy),
    .settled      (settled),
    .settle_cnt   (settle_cnt),
    .fault        (fault)
`ifdef NOR_SETTLE_STATS_EN
    ,
    .max_settle   (max_settle),
    .phase_cnt    (phase_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Settle index: first eval cycle i that completes a run of QUIET quiet cycles; 0 means never within MAX.
  function automatic int model_k(input logic [255:0] pat);
    int run = 0;
    for (int i = 1; i <= MAX; i++) begin
      if (pat[i-1]) run = 0;
      else run++;
      if (run == QUIET) return i;
    end
    return 0;
  endfunction

  task automatic note_settled(input int cnt);
    if (cnt > exp_max) exp_max = cnt;
    exp_phases = (exp_phases + 1) % 65536;
  endtask

  task automatic check_stats(input string nm);
`ifdef NOR_SETTLE_STATS_EN
    chk({nm, "_max_settle"}, max_settle, exp_max);
    chk({nm, "_phase_cnt"}, phase_cnt, exp_phases);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  task automatic do_reset(input string nm);
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    tick_req = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_rst_net_rst_n"}, net_rst_n, 0);
    chk({nm, "_rst_outs"}, {eval_en, phase_strobe, busy, settled, fault}, 0);
    chk({nm, "_rst_settle_cnt"}, settle_cnt, 0);
    exp_max = 0;
    exp_phases = 0;
    check_stats({nm, "_rst"});
    rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (net_rst_n) break;
    end
    chk({nm, "_net_rst_len"}, n, RSTC);
    chk({nm, "_idle_outs"}, {eval_en, phase_strobe, busy, settled, fault}, 0);
  endtask

  // exp_k = 0 means the phase is expected to end in fault
  task automatic run_phase(input logic [255:0] pat, input int exp_k, input string nm);
    int lat, n;
    bit en_ok;
    @(negedge clk);
    tick_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!phase_strobe && lat < 8);
    tick_req = 1'b0;
    chk({nm, "_strobe_lat"}, lat, 1);
    chk({nm, "_apply_busy_en"}, {busy, eval_en}, 2'b10);
    net_changed = 1'($urandom_range(0, 1));
    n = 0;
    en_ok = 1'b1;
    while (n < MAX + 10) begin
      @(negedge clk);
      n++;
      if (settled || fault) break;
      if (!eval_en || !busy || phase_strobe) en_ok = 1'b0;
      net_changed = pat[n-1];
    end
    net_changed = 1'b0;
    chk({nm, "_settle_en_busy"}, en_ok, 1);
    if (exp_k != 0) begin
      chk({nm, "_settle_latency"}, n, exp_k + 2);
      chk({nm, "_settle_cnt"}, settle_cnt, exp_k);
      chk({nm, "_done_flags"}, {settled, fault, busy, eval_en}, 4'b1000);
      note_settled(exp_k);
      check_stats(nm);
      @(negedge clk);
      chk({nm, "_settled_pulse"}, settled, 0);
    end else begin
      chk({nm, "_fault_latency"}, n, MAX + 2);
      chk({nm, "_fault_flags"}, {fault, settled, busy, eval_en}, 4'b1000);
      chk({nm, "_fault_cnt"}, settle_cnt, MAX);
    end
  endtask

  initial begin
    logic [255:0] pat;
    int st[3];
    int ns, t, len, gap;

    tbl[0] = '{32'h0000_0000, 3};
    tbl[1] = '{32'h0000_0025, 9};
    tbl[2] = '{32'h0000_0003, 5};
    tbl[3] = '{32'h0000_0001, 4};
    tbl[4] = '{32'h0000_000F, 7};
    tbl[5] = '{32'h0000_0006, 6};
    tbl[6] = '{32'h0000_0049, 10};
    tbl[7] = '{32'h0000_0005, 6};

    do_reset("init");

    for (int v = 0; v < 8; v++) begin
      pat = '0;
      pat[31:0] = tbl[v].pat;
      run_phase(pat, tbl[v].exp_cnt, $sformatf("tbl%0d", v));
    end

    // back-to-back phases with tick_req held
    @(negedge clk);
    tick_req = 1'b1;
    net_changed = 1'b0;
    st[0] = 0; st[1] = 0; st[2] = 0;
    ns = 0;
    t = 0;
    while (ns < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (phase_strobe) begin
        st[ns] = t;
        ns++;
      end
      if (settled) begin
        chk("b2b_settle_cnt", settle_cnt, 3);
        note_settled(3);
      end
    end
    tick_req = 1'b0;
    t = 0;
    while (!settled && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_last_settled", settled, 1);
    chk("b2b_last_cnt", settle_cnt, 3);
    note_settled(3);
    chk("b2b_strobes", ns, 3);
    chk("b2b_gap1", st[1] - st[0], 6);
    chk("b2b_gap2", st[2] - st[1], 6);
    check_stats("b2b");

    for (int r = 0; r < 25; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      len = $urandom_range(0, 30);
      pat = '0;
      for (int i = 0; i < len; i++) pat[i] = 1'($urandom_range(0, 1));
      if (len > 0 && $urandom_range(0, 1) == 1) pat[len-1] = 1'b1;
      run_phase(pat, model_k(pat), $sformatf("rnd%0d", r));
    end

    // quiet window completes on exactly the last allowed eval cycle
    pat = '0;
    for (int i = 0; i < MAX - QUIET; i++) pat[i] = (i % 2 == 0);
    chk("tie_model", model_k(pat), MAX);
    run_phase(pat, MAX, "tie");

    // reset while in SETTLE cycle 10
    @(negedge clk);
    tick_req = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!phase_strobe && t < 8);
    tick_req = 1'b0;
    net_changed = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy_en", {busy, eval_en}, 0);
    chk("mid_rst_net_rst_n", net_rst_n, 0);
    chk("mid_rst_settle_cnt", settle_cnt, 0);
    net_changed = 1'b0;
    do_reset("post_mid");

    // oscillating netlist
    pat = '0;
    for (int i = 0; i < 256; i++) pat[i] = (i % 2 == 0);
    run_phase(pat, 0, "osc");
    @(negedge clk);
    tick_req = 1'b1;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (phase_strobe || busy || eval_en) ns++;
    end
    tick_req = 1'b0;
    chk("fault_ignores_tick", ns, 0);
    chk("fault_sticky", fault, 1);
    chk("fault_cnt_held", settle_cnt, MAX);
    do_reset("after_fault");
    chk("fault_cleared", fault, 0);
    run_phase('0, 3, "after_fault_phase");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
